// File: rtl/vga_grid_dumper.sv
// Frame grabber: samples a GRID_W x GRID_H cell window of the live VGA pixel stream
// into a 1-bit-per-cell store, then streams it out as ASCII art over a valid/ready byte port.
module vga_grid_dumper #(
    parameter int GRID_W   = 100,
    parameter int GRID_H   = 100,
    parameter int CELL_PX  = 1,
    parameter int X_OFFSET = 270,
    parameter int Y_OFFSET = 190,
    parameter int DARK_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       blank_b,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic       start,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       done
);

    localparam int DEPTH = GRID_W * GRID_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0]    COL_LAST  = 8'(GRID_W - 1);
    localparam logic [7:0]    ROW_LAST  = 8'(GRID_H - 1);
    localparam logic [7:0]    COL_LF    = 8'(GRID_W);
    localparam logic [10:0]   TX_START  = 11'(X_OFFSET);
    localparam logic [10:0]   TY_START  = 11'(Y_OFFSET);
    localparam logic [10:0]   STEP      = 11'(CELL_PX);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [7:0]    DARK_LIM  = 8'(DARK_MAX);
    localparam logic [7:0]    CH_DARK   = 8'h23;
    localparam logic [7:0]    CH_LIT    = 8'h20;
    localparam logic [7:0]    CH_LF     = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    function automatic logic is_dark(input logic [7:0] rv, input logic [7:0] gv,
                                     input logic [7:0] bv);
        is_dark = (rv <= DARK_LIM) && (gv <= DARK_LIM) && (bv <= DARK_LIM);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [7:0]      ci_r, cj_r;
    logic [10:0]     tx_r, ty_r;
    logic [AW-1:0]   wr_addr_r;
    logic            mem_r [0:DEPTH-1];

    logic            frame_s, hit_s, wr_en_s, last_cell_s;
    logic [7:0]      pos_col_r, pos_row_r;
    logic [AW-1:0]   rd_addr_r, rd_addr_nxt_s;
    logic            rd_bit_r, prime_r, last_r;
    logic            out_valid_r, done_r, busy_r;
    logic [7:0]      out_char_r;
    logic            accept_s, load_s, load_lf_s, load_final_s;

    assign frame_s      = blank_b && (x == 10'd0) && (y == 10'd0);
    assign hit_s        = blank_b && ({1'b0, x} == tx_r) && ({1'b0, y} == ty_r);
    // In ARM a hit can only coincide with the frame origin when the window sits at (0,0).
    assign wr_en_s      = hit_s && ((state_r == ST_CAPTURE) || ((state_r == ST_ARM) && frame_s));
    assign last_cell_s  = (ci_r == COL_LAST) && (cj_r == ROW_LAST);
    assign accept_s     = out_valid_r && out_ready;
    assign load_lf_s    = (pos_col_r == COL_LF);
    assign load_final_s = load_lf_s && (pos_row_r == ROW_LAST);
    assign load_s       = (state_r == ST_DRAIN) && prime_r && !last_r && (!out_valid_r || out_ready);

    // Next-state logic for the grab/drain sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_ARM;
                else       state_nxt_s = ST_IDLE;
            end
            ST_ARM: begin
                if (frame_s) state_nxt_s = (wr_en_s && last_cell_s) ? ST_DRAIN : ST_CAPTURE;
                else         state_nxt_s = ST_ARM;
            end
            ST_CAPTURE: begin
                if (wr_en_s && last_cell_s) state_nxt_s = ST_DRAIN;
                else                        state_nxt_s = ST_CAPTURE;
            end
            ST_DRAIN: begin
                if (accept_s && last_r) state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_r == ST_DRAIN) && accept_s && last_r;
        end
    end

    // Capture cursor: cell indices, pixel targets and write address advance by increment only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ci_r      <= 8'd0;
            cj_r      <= 8'd0;
            tx_r      <= 11'd0;
            ty_r      <= 11'd0;
            wr_addr_r <= {AW{1'b0}};
        end else if (state_r == ST_IDLE) begin
            ci_r      <= 8'd0;
            cj_r      <= 8'd0;
            tx_r      <= TX_START;
            ty_r      <= TY_START;
            wr_addr_r <= {AW{1'b0}};
        end else if (wr_en_s) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
            if (ci_r == COL_LAST) begin
                ci_r <= 8'd0;
                tx_r <= TX_START;
                cj_r <= cj_r + 8'd1;
                ty_r <= ty_r + STEP;
            end else begin
                ci_r <= ci_r + 8'd1;
                tx_r <= tx_r + STEP;
            end
        end
    end

    // Read address runs one step ahead so rd_bit_r always holds the cell at rd_addr_r.
    always_comb begin
        rd_addr_nxt_s = rd_addr_r;
        if (state_r != ST_DRAIN) begin
            rd_addr_nxt_s = {AW{1'b0}};
        end else if (load_s && !load_lf_s && (rd_addr_r != ADDR_LAST)) begin
            rd_addr_nxt_s = rd_addr_r + ADDR_ONE;
        end else begin
            rd_addr_nxt_s = rd_addr_r;
        end
    end

    // Bit store: written during capture, synchronous read during drain; contents persist.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            mem_r[wr_addr_r] <= is_dark(r, g, b);
        end
        rd_bit_r <= mem_r[rd_addr_nxt_s];
    end

    // Drain cursor and output byte register with valid/ready hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_col_r   <= 8'd0;
            pos_row_r   <= 8'd0;
            rd_addr_r   <= {AW{1'b0}};
            prime_r     <= 1'b0;
            last_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
        end else begin
            rd_addr_r <= rd_addr_nxt_s;
            prime_r   <= (state_r == ST_DRAIN);
            if (state_r != ST_DRAIN) begin
                pos_col_r   <= 8'd0;
                pos_row_r   <= 8'd0;
                last_r      <= 1'b0;
                out_valid_r <= 1'b0;
            end else if (load_s) begin
                out_valid_r <= 1'b1;
                out_char_r  <= load_lf_s ? CH_LF : (rd_bit_r ? CH_DARK : CH_LIT);
                last_r      <= load_final_s;
                if (load_lf_s) begin
                    pos_col_r <= 8'd0;
                    pos_row_r <= pos_row_r + 8'd1;
                end else begin
                    pos_col_r <= pos_col_r + 8'd1;
                end
            end else if (accept_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;

endmodule

// File: tb/tb_vga_grid_dumper.sv
// Scoreboard bench: two grabbers (offset window and origin window) watch a synthetic raster;
// expected ASCII dumps are computed from the random image and checked by a separate monitor.
module tb_vga_grid_dumper;

    localparam int GW0 = 6, GH0 = 4, CP0 = 3, XO0 = 5, YO0 = 2, DM0 = 16;
    localparam int GW1 = 4, GH1 = 2, CP1 = 8, XO1 = 0, YO1 = 0, DM1 = 0;
    localparam int HTOT = 40, HVIS = 32, VTOT = 24, VVIS = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       blank_b;
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic       rdy0, rdy1, ov0, ov1, bz0, bz1, dn0, dn1;
    logic [7:0] ch0, ch1;

    vga_grid_dumper #(.GRID_W(GW0), .GRID_H(GH0), .CELL_PX(CP0), .X_OFFSET(XO0),
                      .Y_OFFSET(YO0), .DARK_MAX(DM0)) u0 (
        .clk(clk), .reset(reset), .x(x), .y(y), .blank_b(blank_b), .r(r), .g(g), .b(b),
        .start(start), .busy(bz0), .out_valid(ov0), .out_ready(rdy0), .out_char(ch0), .done(dn0));

    vga_grid_dumper #(.GRID_W(GW1), .GRID_H(GH1), .CELL_PX(CP1), .X_OFFSET(XO1),
                      .Y_OFFSET(YO1), .DARK_MAX(DM1)) u1 (
        .clk(clk), .reset(reset), .x(x), .y(y), .blank_b(blank_b), .r(r), .g(g), .b(b),
        .start(start), .busy(bz1), .out_valid(ov1), .out_ready(rdy1), .out_char(ch1), .done(dn1));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int bp_mode = 0;
    logic [23:0] img [0:VVIS-1][0:HVIS-1];
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          rp[2]   = '{0, 0};
    int          acc[2]  = '{0, 0};
    int          dcnt[2] = '{0, 0};
    bit          xd[2]   = '{1'b0, 1'b0};
    bit          ps[2]   = '{1'b0, 1'b0};
    logic [7:0]  pc[2]   = '{8'h00, 8'h00};

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qat(input int k, input int i);
        return (k == 0) ? q0[i] : q1[i];
    endfunction

    task automatic fill_img();
        logic [23:0] c;
        for (int yy = 0; yy < VVIS; yy++) begin
            for (int xx = 0; xx < HVIS; xx++) begin
                case ($urandom_range(0, 3))
                    0: c = 24'h000000;
                    1: c = 24'h101010;
                    2: begin
                        c = 24'h000000;
                        c[8*$urandom_range(0, 2) +: 8] = 8'd17;
                    end
                    default: c = 24'($urandom());
                endcase
                img[yy][xx] = c;
            end
        end
    endtask

    // Reference model: sample cell (ci,cj) at pixel (xo+ci*cp, yo+cj*cp) and render the ASCII dump.
    task automatic gen(input int k);
        int gw, gh, cp, xo, yo, dm;
        logic [23:0] c;
        logic [7:0]  e;
        gw = (k == 0) ? GW0 : GW1;  gh = (k == 0) ? GH0 : GH1;
        cp = (k == 0) ? CP0 : CP1;  dm = (k == 0) ? DM0 : DM1;
        xo = (k == 0) ? XO0 : XO1;  yo = (k == 0) ? YO0 : YO1;
        for (int cj = 0; cj < gh; cj++) begin
            for (int ci = 0; ci <= gw; ci++) begin
                if (ci == gw) begin
                    e = 8'h0A;
                end else begin
                    c = img[yo + cj*cp][xo + ci*cp];
                    e = (c[23:16] <= dm && c[15:8] <= dm && c[7:0] <= dm) ? 8'h23 : 8'h20;
                end
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // Raster generator and sink ready patterns.
    initial begin
        int hx, vy, cyc;
        hx = 0; vy = 0; cyc = 0;
        forever begin
            blank_b = (hx < HVIS) && (vy < VVIS);
            x = 10'(hx);
            y = 10'(vy);
            {r, g, b} = blank_b ? img[vy][hx] : 24'd0;
            case (bp_mode)
                1:       begin rdy0 = ($urandom_range(0, 2) != 0); rdy1 = ($urandom_range(0, 2) != 0); end
                2:       begin rdy0 = (cyc % 4 == 0) || (cyc % 4 == 3); rdy1 = rdy0; end
                default: begin rdy0 = 1'b1; rdy1 = 1'b1; end
            endcase
            @(posedge clk);
            #1;
            cyc++;
            if (hx == HTOT - 1) begin
                hx = 0;
                vy = (vy == VTOT - 1) ? 0 : vy + 1;
            end else begin
                hx++;
            end
        end
    end

    task automatic mon(input int k, input logic ov, input logic rdy, input logic dn,
                       input logic bz, input logic [7:0] ch);
        if (xd[k]) begin
            chk("done_pulse", k, {29'd0, dn, ov, bz}, 32'd4);
            xd[k] = 1'b0;
        end else if (dn) begin
            chk("unexpected_done", k, {31'd0, dn}, 32'd0);
        end
        if (dn) dcnt[k]++;
        if (ps[k]) chk("stall_hold", k, {23'd0, ov, ch}, {23'd0, 1'b1, pc[k]});
        if (ov && rdy) begin
            if (rp[k] >= qsize(k)) begin
                chk("extra_byte", k, {31'd0, ov}, 32'd0);
            end else begin
                chk("byte", k, {24'd0, ch}, {24'd0, qat(k, rp[k])});
                rp[k]++;
                if (rp[k] == qsize(k)) xd[k] = 1'b1;
            end
            acc[k]++;
        end
        ps[k] = ov && !rdy;
        pc[k] = ch;
    endtask

    // Monitor: compares every accepted byte against the scoreboard; reset discards pending bytes.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                rp[k] = qsize(k);
                xd[k] = 1'b0;
                ps[k] = 1'b0;
            end
        end else begin
            mon(0, ov0, rdy0, dn0, bz0, ch0);
            mon(1, ov1, rdy1, dn1, bz1, ch1);
        end
    end

    task automatic run_dump(input int bp, input bit abort);
        int b0, b1, a0;
        bit fin;
        bp_mode = bp;
        fill_img();
        gen(0);
        gen(1);
        b0 = dcnt[0]; b1 = dcnt[1]; a0 = acc[0];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fin = 1'b0;
        if (abort) begin
            for (int t = 0; t < 6000 && !fin; t++) begin
                @(posedge clk); #1;
                fin = (acc[0] >= a0 + 5);
            end
            chk("abort_wait", 0, {31'd0, fin}, 32'd1);
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            chk("abort_busy", 0, {31'd0, bz0}, 32'd0);
            chk("abort_valid", 0, {31'd0, ov0}, 32'd0);
            chk("abort_busy", 1, {31'd0, bz1}, 32'd0);
            chk("abort_valid", 1, {31'd0, ov1}, 32'd0);
            repeat (20) @(posedge clk);
            chk("abort_no_done", 0, dcnt[0], b0);
        end else begin
            for (int t = 0; t < 8000 && !fin; t++) begin
                @(posedge clk); #1;
                fin = (dcnt[0] > b0) && (dcnt[1] > b1);
                start = !fin && bz0 && bz1 && ($urandom_range(0, 30) == 0);
            end
            start = 1'b0;
            chk("dump_timeout", 0, {31'd0, fin}, 32'd1);
            repeat (10) @(posedge clk);
            chk("done_count", 0, dcnt[0], b0 + 1);
            chk("done_count", 1, dcnt[1], b1 + 1);
            chk("bytes_left", 0, qsize(0) - rp[0], 32'd0);
            chk("bytes_left", 1, qsize(1) - rp[1], 32'd0);
        end
    endtask

    initial begin
        fill_img();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 0, {31'd0, bz0}, 32'd0);
        chk("rst_valid", 0, {31'd0, ov0}, 32'd0);
        chk("rst_char", 0, {24'd0, ch0}, 32'd0);
        chk("rst_done", 0, {31'd0, dn0}, 32'd0);
        chk("rst_busy", 1, {31'd0, bz1}, 32'd0);
        chk("rst_valid", 1, {31'd0, ov1}, 32'd0);
        chk("rst_char", 1, {24'd0, ch1}, 32'd0);
        chk("rst_done", 1, {31'd0, dn1}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        run_dump(0, 1'b0);
        run_dump(1, 1'b0);
        run_dump(2, 1'b0);
        for (int i = 0; i < 4; i++) run_dump($urandom_range(0, 2), 1'b0);
        run_dump(0, 1'b1);
        run_dump(2, 1'b0);
        run_dump(1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
